ps2_letter_decoder: RTL and testbench
=====================================

Name: ps2_letter_decoder

Overview:
- Sits between the PS/2 keyboard receiver (scan_code/scan_ready) and the rotor stage of the Enigma datapath.
- Turns the raw PS/2 set-2 byte stream into clean keystroke events: one one-hot 26-bit letter plus a single-cycle strobe per physical key press.
- Strips break (F0) and extended (E0) sequences and suppresses typematic auto-repeat.
- Generates the receiver's read acknowledge, replacing the free-running oneshot.

Parameters:
- REPEAT_SUPPRESS, 1, when 1 a repeated make code of the currently held letter produces no event; when 0 every make code produces an event.

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- scan_code  input  8  byte from PS/2 receiver, stable while scan_ready high
- scan_ready  input  1  level, high while a received byte is pending
- read  output  1  one-cycle acknowledge to receiver, one per accepted byte
- letter  output  26  one-hot last emitted letter (bit0=A ... bit25=Z)
- letter_idx  output  5  binary index of last emitted letter (0=A ... 25=Z)
- key_strobe  output  1  one-cycle pulse per new keystroke event; drives rotor step
- key_held  output  1  high while the last emitted letter has not seen its break code

Behaviour:
- Reset (asynchronous, any time): FSM=IDLE, scan_ready_q=0, held_valid=0, held_idx=0, read=0, letter=0, letter_idx=0, key_strobe=0, key_held=0.
- Byte acceptance: register scan_ready into scan_ready_q; accept on the edge where scan_ready=1 and scan_ready_q=0.
  - At most one accept per scan_ready high period; scan_ready must drop low before the next byte is accepted.
- read: registered, high for exactly the one cycle after each accepting edge.
- Latency: key_strobe, letter, letter_idx and key_held update on the accepting edge and are visible the following cycle; key_strobe is high coincident with read.
- Letter map: A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A. All other codes are non-letters.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK. Transitions happen only on an accept.
  - IDLE, code F0 -> BREAK.
  - IDLE, code E0 -> EXT.
  - IDLE, letter code L, emit condition met -> emit L and stay IDLE. Emit condition: REPEAT_SUPPRESS=0, or held_valid=0, or held_idx!=L.
  - IDLE, letter code L equal to held_idx with held_valid=1 and REPEAT_SUPPRESS=1 -> no event, stay IDLE.
  - IDLE, non-letter code -> ignore, stay IDLE.
  - BREAK, any code -> IDLE. If the code is a letter equal to held_idx, clear held_valid. Never emits.
  - EXT, code F0 -> EXT_BREAK; any other code -> IDLE, ignored.
  - EXT_BREAK, any code -> IDLE, ignored; held state unchanged.
- Emit: key_strobe=1 for one cycle; letter=one-hot(L); letter_idx=L; held_idx=L; held_valid=1.
- letter and letter_idx hold their value until the next emit; they never return to 0 except on reset.
- Rollover: a new letter pressed while another is held emits immediately and becomes the held letter. A later break of the older letter is consumed and does not clear held_valid.
- key_held = held_valid.
- letter is always zero or exactly one-hot; letter_idx never exceeds 25.

Test Plan:
- Reset, then bytes 1C, F0, 1C (each with scan_ready pulsed) -> one key_strobe; letter=26'h1, letter_idx=0; key_held 1 after 1C and 0 after the break; three read pulses.
- 1C,1C,1C,1C (typematic), F0,1C, then 1C -> exactly two key_strobes (first and last 1C); with REPEAT_SUPPRESS=0 -> five key_strobes.
- E0,75 then E0,F0,75 (arrow up/down) -> no key_strobe; letter unchanged; FSM back in IDLE; a following 24 emits E (letter_idx=4).
- 1A then 15 with no break between -> strobes with letter_idx=25 then 16. Then F0,1A -> key_held stays 1. Then F0,15 -> key_held 0.
- Send F0, assert reset for 2 cycles, then 1C -> emitted as make (strobe, letter_idx=0), not treated as break; all outputs read 0 during reset.
- scan_ready held high for 10 cycles with code 2D -> exactly one read pulse and one strobe (letter_idx=17); re-pulse after low -> repeat suppressed, read still pulses.

Source files
------------

// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 byte stream to one-hot letter keystroke events for the Enigma rotor stage.
// Strips break/extended sequences, optionally suppresses typematic repeat, and acknowledges each byte.
module ps2_letter_decoder #(
  parameter int REPEAT_SUPPRESS = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  scan_code,
  input  logic        scan_ready,
  output logic        read,
  output logic [25:0] letter,
  output logic [4:0]  letter_idx,
  output logic        key_strobe,
  output logic        key_held
);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  state_t      state_q, state_d;
  logic        scan_ready_q;
  logic        read_q, read_d;
  logic        key_strobe_q, key_strobe_d;
  logic [25:0] letter_q, letter_d;
  logic [4:0]  letter_idx_q, letter_idx_d;
  logic        held_valid_q, held_valid_d;
  logic [4:0]  held_idx_q, held_idx_d;

  logic        accept;
  logic        is_letter;
  logic [4:0]  code_idx;

  assign accept = scan_ready && !scan_ready_q;

  // Set-2 make code to alphabet position.
  always_comb begin
    is_letter = 1'b1;
    code_idx  = 5'd0;
    case (scan_code)
      8'h1C: code_idx = 5'd0;
      8'h32: code_idx = 5'd1;
      8'h21: code_idx = 5'd2;
      8'h23: code_idx = 5'd3;
      8'h24: code_idx = 5'd4;
      8'h2B: code_idx = 5'd5;
      8'h34: code_idx = 5'd6;
      8'h33: code_idx = 5'd7;
      8'h43: code_idx = 5'd8;
      8'h3B: code_idx = 5'd9;
      8'h42: code_idx = 5'd10;
      8'h4B: code_idx = 5'd11;
      8'h3A: code_idx = 5'd12;
      8'h31: code_idx = 5'd13;
      8'h44: code_idx = 5'd14;
      8'h4D: code_idx = 5'd15;
      8'h15: code_idx = 5'd16;
      8'h2D: code_idx = 5'd17;
      8'h1B: code_idx = 5'd18;
      8'h2C: code_idx = 5'd19;
      8'h3C: code_idx = 5'd20;
      8'h2A: code_idx = 5'd21;
      8'h1D: code_idx = 5'd22;
      8'h22: code_idx = 5'd23;
      8'h35: code_idx = 5'd24;
      8'h1A: code_idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    read_d       = accept;
    key_strobe_d = 1'b0;
    letter_d     = letter_q;
    letter_idx_d = letter_idx_q;
    held_valid_d = held_valid_q;
    held_idx_d   = held_idx_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (scan_code == CODE_BREAK) begin
            state_d = BREAK;
          end else if (scan_code == CODE_EXT) begin
            state_d = EXT;
          end else if (is_letter &&
                       ((REPEAT_SUPPRESS == 0) || !held_valid_q || (held_idx_q != code_idx))) begin
            key_strobe_d = 1'b1;
            letter_d     = 26'd1 << code_idx;
            letter_idx_d = code_idx;
            held_idx_d   = code_idx;
            held_valid_d = 1'b1;
          end
        end
        BREAK: begin
          state_d = IDLE;
          // A break of an older, rolled-over key is consumed without releasing the held one.
          if (is_letter && held_valid_q && (held_idx_q == code_idx)) begin
            held_valid_d = 1'b0;
          end
        end
        EXT:       state_d = (scan_code == CODE_BREAK) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      scan_ready_q <= 1'b0;
      read_q       <= 1'b0;
      key_strobe_q <= 1'b0;
      letter_q     <= 26'd0;
      letter_idx_q <= 5'd0;
      held_valid_q <= 1'b0;
      held_idx_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      scan_ready_q <= scan_ready;
      read_q       <= read_d;
      key_strobe_q <= key_strobe_d;
      letter_q     <= letter_d;
      letter_idx_q <= letter_idx_d;
      held_valid_q <= held_valid_d;
      held_idx_q   <= held_idx_d;
    end
  end

  assign read       = read_q;
  assign key_strobe = key_strobe_q;
  assign letter     = letter_q;
  assign letter_idx = letter_idx_q;
  assign key_held   = held_valid_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Bench for ps2_letter_decoder: two instances (repeat suppression on/off) share one byte stream
// and are checked against a keystroke-level reference model.
module tb_ps2_letter_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  scan_code;
  logic        scan_ready;

  // Index 0: REPEAT_SUPPRESS=1, index 1: REPEAT_SUPPRESS=0
  logic        o_read   [2];
  logic [25:0] o_letter [2];
  logic [4:0]  o_idx    [2];
  logic        o_stb    [2];
  logic        o_held   [2];

  always #5 clk = ~clk;

  ps2_letter_decoder #(.REPEAT_SUPPRESS(1)) dut_sup (
    .CLOCK_50(clk), .reset(rst), .scan_code(scan_code), .scan_ready(scan_ready),
    .read(o_read[0]), .letter(o_letter[0]), .letter_idx(o_idx[0]),
    .key_strobe(o_stb[0]), .key_held(o_held[0]));

  ps2_letter_decoder #(.REPEAT_SUPPRESS(0)) dut_all (
    .CLOCK_50(clk), .reset(rst), .scan_code(scan_code), .scan_ready(scan_ready),
    .read(o_read[1]), .letter(o_letter[1]), .letter_idx(o_idx[1]),
    .key_strobe(o_stb[1]), .key_held(o_held[1]));

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] letter_map [26];

  // Reference model: pending-prefix flags plus per-variant keystroke view.
  bit          m_after_f0, m_after_e0;
  bit          m_held_valid [2];
  int          m_held_idx   [2];
  int          m_idx        [2];
  bit          m_stb        [2];
  int          strobes_seen [2];
  int          reads_seen   [2];

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (letter_map[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [25:0] onehot(input int i);
    logic [25:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_after_f0 = 0;
    m_after_e0 = 0;
    for (int v = 0; v < 2; v++) begin
      m_held_valid[v] = 0;
      m_held_idx[v]   = 0;
      m_idx[v]        = -1;
      m_stb[v]        = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] code);
    int k;
    k = lookup(code);
    m_stb[0] = 0;
    m_stb[1] = 0;
    if (m_after_e0 && m_after_f0) begin
      m_after_e0 = 0;
      m_after_f0 = 0;
    end else if (m_after_e0) begin
      if (code == 8'hF0) m_after_f0 = 1;
      else m_after_e0 = 0;
    end else if (m_after_f0) begin
      m_after_f0 = 0;
      for (int v = 0; v < 2; v++)
        if (k >= 0 && m_held_valid[v] && m_held_idx[v] == k) m_held_valid[v] = 0;
    end else if (code == 8'hF0) begin
      m_after_f0 = 1;
    end else if (code == 8'hE0) begin
      m_after_e0 = 1;
    end else if (k >= 0) begin
      for (int v = 0; v < 2; v++) begin
        if (!(v == 0 && m_held_valid[v] && m_held_idx[v] == k)) begin
          m_stb[v]        = 1;
          m_idx[v]        = k;
          m_held_idx[v]   = k;
          m_held_valid[v] = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit exp_read);
    for (int v = 0; v < 2; v++) begin
      if (o_read[v] === 1'b1) reads_seen[v]++;
      if (o_stb[v] === 1'b1)  strobes_seen[v]++;
      check($sformatf("read[%0d]", v), 32'(o_read[v]), 32'(exp_read));
      check($sformatf("key_strobe[%0d]", v), 32'(o_stb[v]), 32'(exp_read && m_stb[v]));
      check($sformatf("letter[%0d]", v), 32'(o_letter[v]),
            (m_idx[v] < 0) ? 32'd0 : 32'(onehot(m_idx[v])));
      check($sformatf("letter_idx[%0d]", v), 32'(o_idx[v]),
            (m_idx[v] < 0) ? 32'd0 : 32'(m_idx[v]));
      check($sformatf("key_held[%0d]", v), 32'(o_held[v]), 32'(m_held_valid[v]));
    end
  endtask

  task automatic send(input logic [7:0] code, input int hold);
    @(negedge clk);
    scan_code  = code;
    scan_ready = 1'b1;
    @(posedge clk);
    model_byte(code);
    #1;
    check_all(1'b1);
    $display("byte %02h hold=%0d: strobe=%0b/%0b idx=%0d/%0d held=%0b/%0b", code, hold,
             o_stb[0], o_stb[1], o_idx[0], o_idx[1], o_held[0], o_held[1]);
    for (int c = 1; c < hold; c++) begin
      @(posedge clk);
      #1;
      check_all(1'b0);
    end
    @(negedge clk);
    scan_ready = 1'b0;
    @(posedge clk);
    #1;
    check_all(1'b0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all(1'b0);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      check_all(1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset pulse %0d cycles", cycles);
  endtask

  task automatic clear_counts();
    for (int v = 0; v < 2; v++) begin
      strobes_seen[v] = 0;
      reads_seen[v]   = 0;
    end
  endtask

  logic [7:0] pool [8];

  initial begin
    letter_map = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                   8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                   8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    pool = '{8'hF0, 8'hE0, 8'h1C, 8'h1A, 8'h2D, 8'h75, 8'h15, 8'h00};
    rst        = 1'b1;
    scan_code  = 8'h00;
    scan_ready = 1'b0;
    model_reset();
    clear_counts();
    #1;
    check_all(1'b0);
    do_reset(2);

    // Press/release A
    clear_counts();
    send(8'h1C, 1);
    send(8'hF0, 1);
    send(8'h1C, 1);
    check("A press strobes", 32'(strobes_seen[0]), 32'd1);
    check("A press reads", 32'(reads_seen[0]), 32'd3);
    check("A letter", 32'(o_letter[0]), 32'h1);

    // Typematic repeat of A
    clear_counts();
    send(8'h1C, 2); send(8'h1C, 1); send(8'h1C, 3); send(8'h1C, 1);
    send(8'hF0, 1); send(8'h1C, 1); send(8'h1C, 1);
    check("typematic strobes sup", 32'(strobes_seen[0]), 32'd2);
    check("typematic strobes all", 32'(strobes_seen[1]), 32'd5);

    // Arrow up make/break, then E
    clear_counts();
    send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
    check("ext strobes", 32'(strobes_seen[0] + strobes_seen[1]), 32'd0);
    send(8'h24, 1);
    check("E idx", 32'(o_idx[0]), 32'd4);

    // Rollover Z then Q
    send(8'h1A, 1);
    check("Z idx", 32'(o_idx[0]), 32'd25);
    send(8'h15, 1);
    check("Q idx", 32'(o_idx[0]), 32'd16);
    send(8'hF0, 1); send(8'h1A, 1);
    check("held after old break", 32'(o_held[0]), 32'd1);
    send(8'hF0, 1); send(8'h15, 1);
    check("held after new break", 32'(o_held[0]), 32'd0);

    // Reset between F0 and its code
    send(8'hF0, 1);
    do_reset(2);
    clear_counts();
    send(8'h1C, 1);
    check("post-reset make strobe", 32'(strobes_seen[0]), 32'd1);

    // Long scan_ready high, then repeated R
    clear_counts();
    send(8'h2D, 10);
    check("long ready reads", 32'(reads_seen[0]), 32'd1);
    check("long ready strobes", 32'(strobes_seen[0]), 32'd1);
    check("R idx", 32'(o_idx[0]), 32'd17);
    send(8'h2D, 1);
    check("repeat R reads", 32'(reads_seen[0]), 32'd2);
    check("repeat R strobes sup", 32'(strobes_seen[0]), 32'd1);
    check("repeat R strobes all", 32'(strobes_seen[1]), 32'd2);

    // Randomized byte stream
    for (int n = 0; n < 300; n++) begin
      logic [7:0] b;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8) b = pool[sel];
      else if (sel == 8) b = letter_map[$urandom_range(0, 25)];
      else b = 8'($urandom);
      send(b, int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
